// File: rtl/multi_dataflow_package.sv
// Shared types for the multi-dataflow job sequencer: FSM state encoding and
// the control/flag payloads exchanged with the register file and debug taps.
package multi_dataflow_package;

    localparam int unsigned CNT_LEN = 32;

    typedef enum logic [2:0] {
        FSM_IDLE,
        FSM_STARTING,
        FSM_COMPUTE,
        FSM_UPDATE,
        FSM_TERMINATE
    } engine_fsm_state_t;

    typedef struct packed {
        logic               start;
        logic [CNT_LEN-1:0] len;
    } ctrl_engine_fsm_t;

    typedef struct packed {
        logic               busy;
        logic               done;
        logic               err;
        logic               kernel_ready;
        logic [CNT_LEN-1:0] cnt_out;
    } flags_engine_fsm_t;

endpackage

// File: rtl/multi_dataflow_fsm_watchdog.sv
// Cycle counter that flags a stalled kernel: counts while run_i is high and
// reports expiry once TIMEOUT_CYCLES-1 is reached without a clear.
module multi_dataflow_fsm_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_c
);

    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WD_W-1:0] cnt_d, cnt_q;

    assign expired_c = run_i && (cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

    // Held at zero outside the supervised states so every entry starts fresh.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !run_i) begin
            cnt_d = '0;
        end else if (!expired_c) begin
            cnt_d = cnt_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multi_dataflow_engine_fsm.sv
// Job sequencer in front of the kernel adapter: turns a start trigger into
// streamer/kernel start pulses and micro-loop strobes, and reports job end.
// Optional stall watchdog: define MULTI_DATAFLOW_FSM_WATCHDOG_EN.
module multi_dataflow_engine_fsm
    import multi_dataflow_package::*;
#(
    parameter int unsigned N_IN           = 3,
    parameter int unsigned CNT_W          = CNT_LEN,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic [N_IN-1:0]  src_ready_i,
    input  logic             sink_ready_i,
    input  logic             kernel_ready_i,
    input  logic             kernel_done_i,
    input  logic             kernel_idle_i,
    output logic [N_IN-1:0]  src_start_o,
    output logic             sink_start_o,
    output logic             kernel_start_o,
    output logic             uloop_enable_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] cnt_out_o,
    output logic             err_o
);

    engine_fsm_state_t state_d, state_q;
    logic [CNT_W-1:0]  len_d, len_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic [N_IN-1:0]   src_start_d, src_start_q;
    logic              sink_start_d, sink_start_q;
    logic              kernel_start_d, kernel_start_q;
    logic              uloop_d, uloop_q;
    logic              busy_d, busy_q;
    logic              done_d, done_q;
    logic              err_d, err_q;
    logic              wd_expired_c;

    ctrl_engine_fsm_t  ctrl;
    flags_engine_fsm_t flags;
    logic [1:0]        dbg_unused;

    assign ctrl.start = start_i;
    assign ctrl.len   = CNT_LEN'(len_i);

`ifdef MULTI_DATAFLOW_FSM_WATCHDOG_EN
    logic wd_run, wd_clear;

    assign wd_run   = (state_q == FSM_COMPUTE) || (state_q == FSM_TERMINATE);
    assign wd_clear = clear_i || kernel_done_i;

    multi_dataflow_fsm_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) i_watchdog (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (wd_clear),
        .run_i     (wd_run),
        .expired_c (wd_expired_c)
    );
`else
    assign wd_expired_c = 1'b0;
`endif

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state and registered-pulse logic; clear overrides every state.
    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        cnt_d          = cnt_q;
        err_d          = err_q;
        src_start_d    = '0;
        sink_start_d   = 1'b0;
        kernel_start_d = 1'b0;
        uloop_d        = 1'b0;
        done_d         = 1'b0;

        if (clear_i) begin
            state_d = FSM_IDLE;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                FSM_IDLE: begin
                    if (ctrl.start) begin
                        if (ctrl.len != '0) begin
                            len_d   = CNT_W'(ctrl.len);
                            cnt_d   = '0;
                            err_d   = 1'b0;
                            state_d = FSM_STARTING;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                FSM_STARTING: begin
                    if ((&src_ready_i) && sink_ready_i) begin
                        src_start_d    = '1;
                        sink_start_d   = 1'b1;
                        kernel_start_d = 1'b1;
                        state_d        = FSM_COMPUTE;
                    end
                end
                FSM_COMPUTE: begin
                    if (kernel_done_i) begin
                        cnt_d   = cnt_inc;
                        uloop_d = 1'b1;
                        state_d = (cnt_inc == len_q) ? FSM_TERMINATE : FSM_UPDATE;
                    end else if (wd_expired_c) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = FSM_IDLE;
                    end
                end
                FSM_UPDATE: begin
                    kernel_start_d = 1'b1;
                    state_d        = FSM_COMPUTE;
                end
                FSM_TERMINATE: begin
                    if (kernel_idle_i || wd_expired_c) begin
                        err_d   = err_q | (wd_expired_c & ~kernel_idle_i);
                        done_d  = 1'b1;
                        state_d = FSM_IDLE;
                    end
                end
                default: begin
                    state_d = FSM_IDLE;
                end
            endcase
        end

        busy_d = (state_d != FSM_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= FSM_IDLE;
            len_q          <= '0;
            cnt_q          <= '0;
            err_q          <= 1'b0;
            src_start_q    <= '0;
            sink_start_q   <= 1'b0;
            kernel_start_q <= 1'b0;
            uloop_q        <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            cnt_q          <= cnt_d;
            err_q          <= err_d;
            src_start_q    <= src_start_d;
            sink_start_q   <= sink_start_d;
            kernel_start_q <= kernel_start_d;
            uloop_q        <= uloop_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    // Status payload; kernel_ready is carried only as a debug tap.
    assign flags.busy         = busy_q;
    assign flags.done         = done_q;
    assign flags.err          = err_q;
    assign flags.kernel_ready = kernel_ready_i;
    assign flags.cnt_out      = CNT_LEN'(cnt_q);

    assign dbg_unused = {flags.kernel_ready, ^32'(TIMEOUT_CYCLES)};

    assign src_start_o    = src_start_q;
    assign sink_start_o   = sink_start_q;
    assign kernel_start_o = kernel_start_q;
    assign uloop_enable_o = uloop_q;
    assign busy_o         = flags.busy;
    assign done_o         = flags.done;
    assign err_o          = flags.err;
    assign cnt_out_o      = CNT_W'(flags.cnt_out);

endmodule

// File: tb/tb_multi_dataflow_engine_fsm.sv
// Self-checking bench for multi_dataflow_engine_fsm: table of job vectors with
// a result scoreboard, plus hand sequences for clear, reset and stall cases.
module tb_multi_dataflow_engine_fsm;
    import multi_dataflow_package::*;

    localparam int unsigned N_IN  = 3;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned TMO   = 16;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             clear_i = 1'b0;
    logic             start_i = 1'b0;
    logic [CNT_W-1:0] len_i = '0;
    logic [N_IN-1:0]  src_ready_i = '1;
    logic             sink_ready_i = 1'b1;
    logic             kernel_ready_i = 1'b1;
    logic             kernel_done_i = 1'b0;
    logic             kernel_idle_i = 1'b1;
    logic [N_IN-1:0]  src_start_o;
    logic             sink_start_o;
    logic             kernel_start_o;
    logic             uloop_enable_o;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] cnt_out_o;
    logic             err_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int   kst;
        int   ul;
        int   sst;
        int   cnt;
        logic err;
    } exp_t;

    typedef struct {
        int   len;
        int   gap;
        int   idle_dly;
        int   ready_dly;
        bit   inj;
        bit   restart;
        exp_t exp;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[6];

    multi_dataflow_engine_fsm #(
        .N_IN           (N_IN),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clear_i        (clear_i),
        .start_i        (start_i),
        .len_i          (len_i),
        .src_ready_i    (src_ready_i),
        .sink_ready_i   (sink_ready_i),
        .kernel_ready_i (kernel_ready_i),
        .kernel_done_i  (kernel_done_i),
        .kernel_idle_i  (kernel_idle_i),
        .src_start_o    (src_start_o),
        .sink_start_o   (sink_start_o),
        .kernel_start_o (kernel_start_o),
        .uloop_enable_o (uloop_enable_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .cnt_out_o      (cnt_out_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Drives one job and emulates the kernel; results are checked against the scoreboard at done_o.
    task automatic run_job(input vec_t v);
        exp_t             got;
        exp_t             e;
        int               cyc = 0;
        int               wait_d = -1;
        int               ndone = 0;
        int               idle_cnt = -1;
        int               first_st = -1;
        int               done_cyc = -1;
        int               exp_first;
        logic [CNT_W-1:0] cnt_first = '0;
        bit               saw_busy = 1'b0;
        got = '{0, 0, 0, 0, 1'b0};
        sb_q.push_back(v.exp);
        kernel_idle_i = (v.len == 0);
        src_ready_i   = (v.ready_dly > 0) ? 3'b101 : 3'b111;
        start_i       = 1'b1;
        len_i         = CNT_W'(v.len);
        while (cyc < 500 && done_cyc < 0) begin
            step();
            cyc++;
            start_i       = 1'b0;
            kernel_done_i = 1'b0;
            if (busy_o) saw_busy = 1'b1;
            if (cyc == v.ready_dly) src_ready_i = '1;
            if (src_start_o != '0) begin
                got.sst++;
                check("starts_together", {src_start_o, sink_start_o, kernel_start_o}, 64'h1f);
            end
            if (kernel_start_o) begin
                got.kst++;
                if (first_st < 0) begin
                    first_st  = cyc;
                    cnt_first = cnt_out_o;
                    if (v.restart) begin
                        start_i = 1'b1;
                        len_i   = CNT_W'(99);
                    end
                end
                wait_d = v.gap;
            end
            if (uloop_enable_o) got.ul++;
            if (v.inj && first_st < 0) kernel_done_i = 1'b1;
            if (idle_cnt == 0) kernel_idle_i = 1'b1;
            else if (idle_cnt > 0) idle_cnt--;
            if (wait_d > 0) begin
                wait_d--;
                if (wait_d == 0) begin
                    kernel_done_i = 1'b1;
                    ndone++;
                    if (ndone == v.len) idle_cnt = v.idle_dly;
                end
            end
            if (done_o) done_cyc = cyc;
        end
        start_i       = 1'b0;
        kernel_done_i = 1'b0;
        check("job_done_seen", 64'(done_cyc >= 0), 64'd1);
        if (sb_q.size() == 0) begin
            check("scoreboard_nonempty", 64'(sb_q.size()), 64'd1);
        end else begin
            e = sb_q.pop_front();
            check("kernel_start_count", 64'(got.kst), 64'(e.kst));
            check("uloop_count", 64'(got.ul), 64'(e.ul));
            check("src_start_count", 64'(got.sst), 64'(e.sst));
            check("cnt_out_at_done", 64'(cnt_out_o), 64'(e.cnt));
            check("err_at_done", 64'(err_o), 64'(e.err));
            check("busy_at_done", 64'(busy_o), 64'd0);
            check("busy_seen", 64'(saw_busy), 64'(v.len != 0));
            if (v.len != 0) begin
                exp_first = (v.ready_dly > 0) ? v.ready_dly + 1 : 2;
                check("first_start_cycle", 64'(first_st), 64'(exp_first));
                check("cnt_at_first_start", 64'(cnt_first), 64'd0);
            end else begin
                check("len0_done_cycle", 64'(done_cyc), 64'd1);
            end
        end
        step();
        check("done_one_cycle", 64'(done_o), 64'd0);
        kernel_idle_i = 1'b1;
        src_ready_i   = '1;
    endtask

    initial begin
        int   wait_d;
        int   n;
        bit   hit;
        vec_t v2;

        vecs[0] = '{4, 3, 2, 0,  1'b0, 1'b0, '{4, 4, 1, 4, 1'b0}};
        vecs[1] = '{0, 1, 0, 0,  1'b0, 1'b0, '{0, 0, 0, 4, 1'b0}};
        vecs[2] = '{2, 1, 0, 10, 1'b0, 1'b0, '{2, 2, 1, 2, 1'b0}};
        vecs[3] = '{1, 2, 1, 0,  1'b0, 1'b0, '{1, 1, 1, 1, 1'b0}};
        vecs[4] = '{3, 2, 0, 5,  1'b1, 1'b1, '{3, 3, 1, 3, 1'b0}};
        vecs[5] = '{6, 1, 0, 0,  1'b0, 1'b0, '{6, 6, 1, 6, 1'b0}};
        v2      = '{2, 2, 0, 0,  1'b0, 1'b0, '{2, 2, 1, 2, 1'b0}};

        #12;
        check("reset_outputs",
              {src_start_o, sink_start_o, kernel_start_o, uloop_enable_o, busy_o, done_o, err_o, cnt_out_o}, '0);
        rst_ni = 1'b1;
        step();

        for (int i = 0; i < 6; i++) run_job(vecs[i]);

        // Done pulses while idle must not move the counter.
        for (int i = 0; i < 3; i++) begin
            kernel_done_i = 1'b1;
            step();
        end
        kernel_done_i = 1'b0;
        step();
        check("idle_done_ignored", 64'(cnt_out_o), 64'd6);
        check("idle_done_no_busy", 64'(busy_o), 64'd0);

        // Clear in the middle of an 8-output job.
        kernel_idle_i = 1'b0;
        start_i       = 1'b1;
        len_i         = CNT_W'(8);
        wait_d        = -1;
        hit           = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            step();
            start_i       = 1'b0;
            kernel_done_i = 1'b0;
            if (cnt_out_o == CNT_W'(3)) begin
                clear_i = 1'b1;
                hit     = 1'b1;
            end else begin
                if (kernel_start_o) wait_d = 2;
                if (wait_d > 0) begin
                    wait_d--;
                    if (wait_d == 0) kernel_done_i = 1'b1;
                end
            end
        end
        check("clear_reached_cnt3", 64'(hit), 64'd1);
        step();
        clear_i = 1'b0;
        check("clear_busy", 64'(busy_o), 64'd0);
        check("clear_cnt", 64'(cnt_out_o), 64'd0);
        check("clear_kstart_suppressed", 64'(kernel_start_o), 64'd0);
        n = 0;
        for (int c = 0; c < 5; c++) begin
            if (done_o || kernel_start_o) n++;
            step();
        end
        check("clear_no_done", 64'(n), 64'd0);
        kernel_idle_i = 1'b1;
        run_job(v2);

        // Asynchronous reset mid-job.
        start_i = 1'b1;
        len_i   = CNT_W'(5);
        step();
        start_i = 1'b0;
        step();
        step();
        #2 rst_ni = 1'b0;
        #1;
        check("async_reset_outputs", {busy_o, kernel_start_o, done_o, cnt_out_o}, '0);
        step();
        rst_ni = 1'b1;
        step();
        check("after_reset_idle", 64'(busy_o), 64'd0);

`ifdef MULTI_DATAFLOW_FSM_WATCHDOG_EN
        // Kernel never answers: watchdog aborts the job.
        kernel_idle_i = 1'b0;
        start_i       = 1'b1;
        len_i         = CNT_W'(2);
        n             = -1;
        wait_d        = -1;
        for (int c = 1; c < 60 && n < 0; c++) begin
            step();
            start_i = 1'b0;
            if (kernel_start_o && wait_d < 0) wait_d = c;
            if (done_o) n = c;
        end
        check("wd_done_seen", 64'(n >= 0), 64'd1);
        check("wd_stall_cycles", 64'(n - wait_d), 64'(TMO));
        check("wd_err_set", 64'(err_o), 64'd1);
        check("wd_busy_dropped", 64'(busy_o), 64'd0);
        step();
        check("wd_err_sticky", 64'(err_o), 64'd1);
        kernel_idle_i = 1'b1;
        run_job(vecs[3]);
`else
        // Without the watchdog a stalled kernel just keeps the job open.
        kernel_idle_i = 1'b0;
        start_i       = 1'b1;
        len_i         = CNT_W'(1);
        n             = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            start_i = 1'b0;
            if (done_o) n++;
        end
        check("stall_no_done", 64'(n), 64'd0);
        check("stall_still_busy", 64'(busy_o), 64'd1);
        check("stall_no_err", 64'(err_o), 64'd0);
        kernel_done_i = 1'b1;
        step();
        kernel_done_i = 1'b0;
        kernel_idle_i = 1'b1;
        n             = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (done_o) n++;
        end
        check("stall_released_done", 64'(n), 64'd1);
        check("stall_released_cnt", 64'(cnt_out_o), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
